cfg_clk_div_multi: RTL and testbench

- Multi-channel, run-time configurable clock-enable divider.
- Each channel produces a registered square wave and a single-cycle tick from one fabric clock.
  - Divide ratio, high time and phase offset are programmable per channel.
  - New settings take effect glitch-free at period boundaries.
- A common sync input re-aligns all channels.
- Feeds DAC/ADC decimation, sequencer step timing and external trigger generation.
- Outputs are data-path enables, not clock nets; no global buffer is instantiated.

---
 rtl/cfg_clk_div_pkg.sv | 30 +++
 rtl/cfg_clk_div_ch.sv | 72 +++++++
 rtl/cfg_clk_div_multi.sv | 37 +++
 tb/tb_cfg_clk_div_multi.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_clk_div_pkg.sv
// rtl/cfg_clk_div_pkg.sv - config type, limits and clamp for cfg_clk_div_multi (CFG_CLK_DIV_PHASE_EN)
package cfg_clk_div_pkg;

  localparam int CFG_W   = 32;
  localparam int DIV_MIN = 2;
  localparam int MAX_CH  = 8;

  typedef struct packed {
    logic [CFG_W-1:0] div;
    logic [CFG_W-1:0] high;
    logic [CFG_W-1:0] phase;
  } cfg_t;

  localparam cfg_t CFG_RESET = '{div: CFG_W'(DIV_MIN), high: CFG_W'(1), phase: '0};

  // Applied at capture so the active set is always legal.
  function automatic cfg_t clamp_cfg(input cfg_t raw);
    cfg_t c;
    c = raw;
    if (c.div < CFG_W'(DIV_MIN)) c.div = CFG_W'(DIV_MIN);
    if (c.high > c.div) c.high = c.div;
`ifdef CFG_CLK_DIV_PHASE_EN
    if (c.phase >= c.div) c.phase = c.div - CFG_W'(1);
`else
    c.phase = '0;
`endif
    return c;
  endfunction

endpackage

// File: rtl/cfg_clk_div_ch.sv
// rtl/cfg_clk_div_ch.sv - one divider channel: shadow/active config, counter, registered outputs (CFG_CLK_DIV_PHASE_EN)
module cfg_clk_div_ch
  import cfg_clk_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable,
  input  logic [WIDTH-1:0] cfg_div,
  input  logic [WIDTH-1:0] cfg_high,
  input  logic [WIDTH-1:0] cfg_phase,
  input  logic             cfg_valid,
  input  logic             sync,
  output logic             div_out,
  output logic             div_tick,
  output logic             cfg_pending
);

  cfg_t raw, cap, nxt, act, shd;
  // Upper bits stay zero: cnt < div <= 2^WIDTH-1.
  logic [CFG_W-1:0] cnt;
  logic             apply_pend;
  logic             at_wrap;
  logic             reload;

  always_comb begin
    raw      = '0;
    raw.div  = CFG_W'(cfg_div);
    raw.high = CFG_W'(cfg_high);
`ifdef CFG_CLK_DIV_PHASE_EN
    raw.phase = CFG_W'(cfg_phase);
`endif
  end

`ifndef CFG_CLK_DIV_PHASE_EN
  logic unused_phase;
  assign unused_phase = ^cfg_phase;
`endif

  assign cap        = clamp_cfg(raw);
  assign nxt        = cfg_valid ? cap : shd;
  assign apply_pend = cfg_valid | cfg_pending;
  assign at_wrap    = (cnt == act.div - CFG_W'(1));
  assign reload     = !enable || sync || at_wrap;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      act         <= CFG_RESET;
      shd         <= CFG_RESET;
      cnt         <= '0;
      div_out     <= 1'b0;
      div_tick    <= 1'b0;
      cfg_pending <= 1'b0;
    end else begin
      div_out  <= enable && (cnt < act.high);
      div_tick <= enable && (cnt == '0);
      if (cfg_valid) shd <= cap;
      if (reload) begin
        // Stop, sync and wrap are the only points where a new config may land.
        cfg_pending <= 1'b0;
        if (apply_pend) act <= nxt;
        if (enable && !sync) cnt <= '0;
        else                 cnt <= apply_pend ? nxt.phase : act.phase;
      end else begin
        cfg_pending <= apply_pend;
        cnt         <= cnt + CFG_W'(1);
      end
    end
  end

endmodule

// File: rtl/cfg_clk_div_multi.sv
// rtl/cfg_clk_div_multi.sv - multi-channel configurable clock-enable divider top (CFG_CLK_DIV_PHASE_EN)
module cfg_clk_div_multi
  import cfg_clk_div_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [NUM_CH-1:0]       enable,
  input  logic [NUM_CH*WIDTH-1:0] cfg_div,
  input  logic [NUM_CH*WIDTH-1:0] cfg_high,
  input  logic [NUM_CH*WIDTH-1:0] cfg_phase,
  input  logic [NUM_CH-1:0]       cfg_valid,
  input  logic                    sync,
  output logic [NUM_CH-1:0]       div_out,
  output logic [NUM_CH-1:0]       div_tick,
  output logic [NUM_CH-1:0]       cfg_pending
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    cfg_clk_div_ch #(.WIDTH(WIDTH)) u_ch (
      .clk         (clk),
      .resetn      (resetn),
      .enable      (enable[i]),
      .cfg_div     (cfg_div[i*WIDTH +: WIDTH]),
      .cfg_high    (cfg_high[i*WIDTH +: WIDTH]),
      .cfg_phase   (cfg_phase[i*WIDTH +: WIDTH]),
      .cfg_valid   (cfg_valid[i]),
      .sync        (sync),
      .div_out     (div_out[i]),
      .div_tick    (div_tick[i]),
      .cfg_pending (cfg_pending[i])
    );
  end

endmodule

// File: tb/tb_cfg_clk_div_multi.sv
// tb/tb_cfg_clk_div_multi.sv - scoreboard bench for cfg_clk_div_multi (CFG_CLK_DIV_PHASE_EN aware)
module tb_cfg_clk_div_multi;

  localparam int NCH = 2;
  localparam int W   = 8;
`ifdef CFG_CLK_DIV_PHASE_EN
  localparam int PH1 = 5;
`else
  localparam int PH1 = 0;
`endif

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic [NCH-1:0]   enable = '0;
  logic [NCH*W-1:0] cfg_div = '0;
  logic [NCH*W-1:0] cfg_high = '0;
  logic [NCH*W-1:0] cfg_phase = '0;
  logic [NCH-1:0]   cfg_valid = '0;
  logic             sync = 1'b0;
  logic [NCH-1:0]   div_out, div_tick, cfg_pending;

  typedef struct packed {
    logic [1:0] o;
    logic [1:0] t;
    logic [1:0] p;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int checks = 0;
  int errors = 0;

  cfg_clk_div_multi #(.NUM_CH(NCH), .WIDTH(W)) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .cfg_div(cfg_div),
    .cfg_high(cfg_high), .cfg_phase(cfg_phase), .cfg_valid(cfg_valid),
    .sync(sync), .div_out(div_out), .div_tick(div_tick), .cfg_pending(cfg_pending)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int ch, input int d, input int h, input int ph);
    cfg_div[ch*W +: W]   = W'(d);
    cfg_high[ch*W +: W]  = W'(h);
    cfg_phase[ch*W +: W] = W'(ph);
  endtask

  task automatic load_idle(input logic [NCH-1:0] mask);
    cfg_valid = mask;
    step();
    cfg_valid = '0;
  endtask

  task automatic test_reset();
    repeat (3) step();
    checks++;
    if ({div_out, div_tick, cfg_pending} !== 6'b0) begin
      errors++;
      $display("FAIL reset_hold got %b want %b", {div_out, div_tick, cfg_pending}, 6'b0);
    end
    resetn = 1'b1;
    step();
    checks++;
    if ({div_out, div_tick, cfg_pending} !== 6'b0) begin
      errors++;
      $display("FAIL reset_release got %b want %b", {div_out, div_tick, cfg_pending}, 6'b0);
    end
  endtask

  task automatic test_default();
    enable = 2'b01;
    for (int k = 1; k <= 8; k++) begin
      e = '0; e.o[0] = ((k-1) % 2) < 1; e.t[0] = ((k-1) % 2) == 0;
      sb.push_back(e);
    end
    for (int k = 1; k <= 8; k++) begin
      step(); e = sb.pop_front(); checks++;
      if ({div_out, div_tick, cfg_pending} !== e) begin
        errors++;
        $display("FAIL default k=%0d got %b want %b", k, {div_out, div_tick, cfg_pending}, e);
      end
    end
    enable = '0; step();
  endtask

  task automatic test_div10();
    int c;
    set_cfg(0, 10, 3, 0);
    enable = 2'b01; cfg_valid = 2'b01;
    for (int k = 1; k <= 22; k++) begin
      e = '0;
      if (k == 1) begin e.o[0] = 1'b1; e.t[0] = 1'b1; e.p[0] = 1'b1; end
      else if (k >= 3) begin c = (k-3) % 10; e.o[0] = c < 3; e.t[0] = c == 0; end
      sb.push_back(e);
    end
    for (int k = 1; k <= 22; k++) begin
      step(); e = sb.pop_front(); checks++;
      if ({div_out, div_tick, cfg_pending} !== e) begin
        errors++;
        $display("FAIL div10 k=%0d got %b want %b", k, {div_out, div_tick, cfg_pending}, e);
      end
      if (k == 1) cfg_valid = '0;
    end
    enable = '0; step();
  endtask

  task automatic test_reconfig();
    int c;
    enable = 2'b01;
    for (int k = 1; k <= 22; k++) begin
      e = '0;
      if (k <= 10) begin
        c = k - 1; e.o[0] = c < 3; e.t[0] = c == 0; e.p[0] = (k >= 6 && k <= 9);
      end else begin
        c = (k-11) % 4; e.o[0] = c < 2; e.t[0] = c == 0;
      end
      sb.push_back(e);
    end
    for (int k = 1; k <= 22; k++) begin
      step(); e = sb.pop_front(); checks++;
      if ({div_out, div_tick, cfg_pending} !== e) begin
        errors++;
        $display("FAIL reconfig k=%0d got %b want %b", k, {div_out, div_tick, cfg_pending}, e);
      end
      if (k == 5) begin set_cfg(0, 4, 2, 0); cfg_valid = 2'b01; end
      if (k == 6) cfg_valid = '0;
    end
    enable = '0; step();
  endtask

  task automatic test_sync_phase();
    int n, c0, c1;
    set_cfg(0, 10, 3, 0);
    set_cfg(1, 10, 3, 5);
    load_idle(2'b11);
    enable = 2'b11;
    for (int k = 1; k <= 20; k++) begin
      n = (k-1 <= 3) ? k-1 : k-5;
      c0 = n % 10; c1 = (PH1 + n) % 10;
      e = '0;
      e.o[0] = c0 < 3; e.t[0] = c0 == 0;
      e.o[1] = c1 < 3; e.t[1] = c1 == 0;
      sb.push_back(e);
    end
    for (int k = 1; k <= 20; k++) begin
      step(); e = sb.pop_front(); checks++;
      if ({div_out, div_tick, cfg_pending} !== e) begin
        errors++;
        $display("FAIL sync_phase k=%0d got %b want %b", k, {div_out, div_tick, cfg_pending}, e);
      end
      if (k == 3) sync = 1'b1;
      if (k == 4) sync = 1'b0;
    end
    enable = '0; step();
  endtask

  task automatic test_clamp();
    int td[3] = '{0, 8, 8};
    int th[3] = '{1, 20, 0};
    int tp[3] = '{2, 8, 8};
    int tq[3] = '{1, 8, 0};
    int c;
    for (int i = 0; i < 3; i++) begin
      set_cfg(0, td[i], th[i], 0);
      load_idle(2'b01);
      enable = 2'b01;
      for (int k = 1; k <= 16; k++) begin
        c = (k-1) % tp[i];
        e = '0; e.o[0] = c < tq[i]; e.t[0] = c == 0;
        sb.push_back(e);
      end
      for (int k = 1; k <= 16; k++) begin
        step(); e = sb.pop_front(); checks++;
        if ({div_out, div_tick, cfg_pending} !== e) begin
          errors++;
          $display("FAIL clamp%0d k=%0d got %b want %b", i, k, {div_out, div_tick, cfg_pending}, e);
        end
      end
      enable = '0; step();
    end
  endtask

  task automatic test_reset_mid();
    set_cfg(0, 10, 3, 0);
    load_idle(2'b01);
    enable = 2'b01;
    repeat (2) step();
    set_cfg(0, 6, 2, 0);
    cfg_valid = 2'b01;
    step();
    cfg_valid = '0;
    checks++;
    if ({div_out, div_tick, cfg_pending} !== 6'b01_00_01) begin
      errors++;
      $display("FAIL mid_pending got %b want %b", {div_out, div_tick, cfg_pending}, 6'b01_00_01);
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({div_out, div_tick, cfg_pending} !== 6'b0) begin
      errors++;
      $display("FAIL mid_async got %b want %b", {div_out, div_tick, cfg_pending}, 6'b0);
    end
    step();
    checks++;
    if ({div_out, div_tick, cfg_pending} !== 6'b0) begin
      errors++;
      $display("FAIL mid_held got %b want %b", {div_out, div_tick, cfg_pending}, 6'b0);
    end
    resetn = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      e = '0; e.o[0] = ((k-1) % 2) < 1; e.t[0] = ((k-1) % 2) == 0;
      sb.push_back(e);
    end
    for (int k = 1; k <= 6; k++) begin
      step(); e = sb.pop_front(); checks++;
      if ({div_out, div_tick, cfg_pending} !== e) begin
        errors++;
        $display("FAIL mid_defaults k=%0d got %b want %b", k, {div_out, div_tick, cfg_pending}, e);
      end
    end
    enable = '0; step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_default();
    test_div10();
    test_reconfig();
    test_sync_phase();
    test_clamp();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
